// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared core definitions: jump-op codes, PC sequencer state
//                encoding, default reset vector and instruction-length coding.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    // Jump-condition unit operation codes
    typedef enum logic [2:0] {
        ZERO          = 3'd0,
        NOT_ZERO      = 3'd1,
        NEGATIVE      = 3'd2,
        POSITIVE      = 3'd3,
        UNCONDITIONAL = 3'd4
    } jmp_op_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } pc_state_t;

    typedef enum logic [0:0] {
        LEN_1W = 1'b0,
        LEN_2W = 1'b1
    } inst_len_t;

    localparam logic [31:0] c_default_reset_vector = 32'h0000_0000;
    localparam int          c_flush_cnt_w          = 3;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/flush_timer.sv
// ============================================================================
//  Module      : flush_timer
//  Description : Loadable down-counter that stops at zero and flags done.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module flush_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign done = (r_cnt == '0);

endmodule : flush_timer

`default_nettype wire

// File: rtl/pc_redirect.sv
// ============================================================================
//  Module      : pc_redirect
//  Description : Fetch PC sequencer with jump redirect, timed IF/ID flush,
//                stall hold and reset vector. Optional taken-jump statistics
//                counter enabled by macro PC_REDIRECT_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_redirect
    import cpu_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(c_default_reset_vector),
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              stall,
    input  logic              inst_len2,
    output logic [ADDR_W-1:0] pc,
    output logic              flush,
    output logic              redirect,
    output logic [15:0]       jmp_count
);

    localparam logic [c_flush_cnt_w-1:0] c_flush_load = c_flush_cnt_w'(FLUSH_CYCLES - 1);

    pc_state_t         r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt, w_step;
    logic              r_flush, w_flush_nxt;
    logic              r_redirect, w_redirect_nxt;
    logic              w_load, w_dec, w_timer_done;

    assign w_step = (inst_len_t'(inst_len2) == LEN_2W) ? ADDR_W'(2) : ADDR_W'(1);

    flush_timer #(
        .CNT_W (c_flush_cnt_w)
    ) u_flush_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (c_flush_load),
        .dec      (w_dec),
        .done     (w_timer_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_VECTOR;
            r_flush    <= 1'b0;
            r_redirect <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_flush    <= w_flush_nxt;
            r_redirect <= w_redirect_nxt;
        end
    end

    // jmp_target only reaches the PC mux on an accepted jump, so X on it is harmless otherwise
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_flush_nxt    = 1'b0;
        w_redirect_nxt = 1'b0;
        w_load         = 1'b0;
        w_dec          = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (jmp) begin
                    w_pc_nxt       = jmp_target;
                    w_redirect_nxt = 1'b1;
                    w_flush_nxt    = 1'b1;
                    w_load         = 1'b1;
                    w_state_nxt    = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                end else if (!stall) begin
                    w_pc_nxt = r_pc + w_step;
                end
            end
            ST_FLUSH: begin
                if (!stall) begin
                    w_pc_nxt = r_pc + w_step;
                end
                if (w_timer_done) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_flush_nxt = 1'b1;
                    w_dec       = 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign pc       = r_pc;
    assign flush    = r_flush;
    assign redirect = r_redirect;

`ifdef PC_REDIRECT_STATS_EN
    logic [15:0] r_jmp_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_jmp_count <= 16'h0000;
        end else if (w_redirect_nxt && (r_jmp_count != 16'hFFFF)) begin
            r_jmp_count <= r_jmp_count + 16'h0001;
        end
    end

    assign jmp_count = r_jmp_count;
`else
    assign jmp_count = 16'h0000;
`endif

endmodule : pc_redirect

`default_nettype wire
